// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 2-digit seven-segment display with minimum hold before preemption.
// Optional build macro SEG_BLANK_IDLE_EN blanks the segments whenever nobody owns the display.
module seg_display_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned SCAN_DIV    = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       value,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     busy,
    output logic [7:0]               digit_seg,
    output logic [1:0]               digit_cath
);
    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] LAST_ID  = IW'(N_REQ - 1);

    typedef enum logic {StIdle, StOwn} state_t;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [HW-1:0]    hold;
    logic [7:0]       latched;
    logic [SW-1:0]    scan_cnt;
    logic             sel;

    logic [IW-1:0]    next_id;
    logic [IW-1:0]    search_start;
    logic [N_REQ-1:0] search_mask;
    logic             found;
    logic [IW-1:0]    pick;
    logic [N_REQ-1:0] pick_onehot;
    logic [7:0]       owner_val;
    logic [3:0]       nibble;
    logic [7:0]       seg_hex;
    int unsigned      idx;

    assign next_id   = (owner_id == LAST_ID) ? '0 : owner_id + 1'b1;
    assign owner_val = value[{owner_id, 3'b000} +: 8];

    // While owning, the search excludes the owner and starts just after it.
    assign search_start = (state == StOwn) ? next_id : ptr;
    assign search_mask  = (state == StOwn) ? (req & ~gnt) : req;

    always_comb begin
        found       = 1'b0;
        pick        = '0;
        idx         = 0;
        pick_onehot = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = (int'(search_start) + k) % N_REQ;
            if (!found && search_mask[IW'(idx)]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
        pick_onehot[pick] = found;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            gnt      <= '0;
            owner_id <= '0;
            ptr      <= '0;
            hold     <= '0;
            latched  <= 8'h00;
        end else begin
            case (state)
                StIdle: begin
                    if (found) begin
                        state    <= StOwn;
                        gnt      <= pick_onehot;
                        owner_id <= pick;
                        hold     <= '0;
                    end
                end
                StOwn: begin
                    latched <= owner_val;
                    if (!req[owner_id]) begin
                        ptr  <= next_id;
                        hold <= '0;
                        if (found) begin
                            gnt      <= pick_onehot;
                            owner_id <= pick;
                        end else begin
                            state    <= StIdle;
                            gnt      <= '0;
                            owner_id <= '0;
                        end
                    end else if (found && hold == HOLD_MAX) begin
                        ptr      <= next_id;
                        gnt      <= pick_onehot;
                        owner_id <= pick;
                        hold     <= '0;
                    end else if (hold != HOLD_MAX) begin
                        hold <= hold + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy = |gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            sel      <= 1'b0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            sel      <= ~sel;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        nibble  = sel ? latched[7:4] : latched[3:0];
        seg_hex = 8'h00;
        case (nibble)
            4'h0: seg_hex = 8'hFC;
            4'h1: seg_hex = 8'h60;
            4'h2: seg_hex = 8'hDA;
            4'h3: seg_hex = 8'hF2;
            4'h4: seg_hex = 8'h66;
            4'h5: seg_hex = 8'hB6;
            4'h6: seg_hex = 8'hBE;
            4'h7: seg_hex = 8'hE0;
            4'h8: seg_hex = 8'hFE;
            4'h9: seg_hex = 8'hF6;
            4'hA: seg_hex = 8'hEE;
            4'hB: seg_hex = 8'h3E;
            4'hC: seg_hex = 8'h9C;
            4'hD: seg_hex = 8'h7A;
            4'hE: seg_hex = 8'h9E;
            4'hF: seg_hex = 8'h8E;
            default: seg_hex = 8'h00;
        endcase
    end

    assign digit_cath = {sel, ~sel};

`ifdef SEG_BLANK_IDLE_EN
    assign digit_seg = busy ? seg_hex : 8'h00;
`else
    assign digit_seg = seg_hex;
`endif

endmodule
